rmii_rx_fcs_check: RTL

- Sits between the RMII receive byte engine and the RX FIFO, in the REF_CLK domain.
- Consumes the byte stream (data, write strobe, end-of-data) and checks the Ethernet CRC-32.
- Strips the 4 FCS bytes and appends one status byte, flagged as end-of-data, to each frame in the FIFO.
- Keeps gray-coded error counters for the user clock domain.

---
 rtl/eth_pkg.sv | 25 ++
 rtl/eth_crc32_d8.sv | 25 ++
 rtl/rmii_rx_fcs_check.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
// Shared constants, status bit positions and state encoding for the RMII RX FCS checker.
package eth_pkg;

  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  localparam int ST_FCS_OK = 0;
  localparam int ST_RUNT   = 1;
  localparam int ST_GIANT  = 2;
  localparam int ST_SHORT  = 3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FILL   = 2'd1,
    S_STREAM = 2'd2,
    S_STATUS = 2'd3
  } rx_state_e;

  // Binary-to-gray conversion for counters read from the user clock domain.
  function automatic logic [15:0] bin2gray(input logic [15:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/eth_crc32_d8.sv
// One-byte step of the reflected Ethernet CRC-32, LSB of the data byte first.
module eth_crc32_d8
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  logic [31:0] w_acc;

  // Eight unrolled shift/xor iterations.
  always_comb begin
    w_acc = crc_in ^ {24'd0, data};
    for (int i = 0; i < 8; i++) begin
      if (w_acc[0]) begin
        w_acc = (w_acc >> 1) ^ CRC_POLY;
      end else begin
        w_acc = w_acc >> 1;
      end
    end
    crc_out = w_acc;
  end

endmodule

// File: rtl/rmii_rx_fcs_check.sv
// Checks the Ethernet FCS of each received frame, strips the FCS bytes and
// appends a status byte (with EOD) to the frame written into the RX FIFO.
module rmii_rx_fcs_check
  import eth_pkg::*;
#(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518,
  parameter int LEN_W   = 12
) (
  input  logic        REF_CLK,
  input  logic        arst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_eod,
  output logic        in_afull,
  input  logic        fifo_afull,
  output logic [7:0]  fifo_din,
  output logic        fifo_wren,
  output logic        fifo_EOD_in,
  output logic [15:0] fcs_err_count_gray,
  output logic [15:0] len_err_count_gray
);

  rx_state_e        r_state;
  logic [31:0]      r_crc;
  logic [3:0][7:0]  r_dly;
  logic [2:0]       r_fill;
  logic [LEN_W-1:0] r_count;
  logic [7:0]       r_status;
  logic [15:0]      r_fcs_cnt;
  logic [15:0]      r_len_cnt;
  logic [15:0]      r_fcs_gray;
  logic [15:0]      r_len_gray;

  logic             w_start;
  logic [31:0]      w_crc_base;
  logic [31:0]      w_crc_next;
  logic [LEN_W-1:0] w_count_next;
  logic [2:0]       w_fill_next;
  logic [7:0]       w_status_next;
  logic [15:0]      w_fcs_cnt_next;
  logic [15:0]      w_len_cnt_next;

  // A byte arriving in S_STATUS begins a new frame exactly as in S_IDLE.
  assign w_start    = (r_state == S_IDLE) || (r_state == S_STATUS);
  assign w_crc_base = w_start ? CRC_INIT : r_crc;

  eth_crc32_d8 u_crc (
    .crc_in  (w_crc_base),
    .data    (in_data),
    .crc_out (w_crc_next)
  );

  assign in_afull = fifo_afull;

  assign w_fill_next    = w_start ? 3'd1 : ((r_fill == 3'd4) ? 3'd4 : r_fill + 3'd1);
  assign w_fcs_cnt_next = r_fcs_cnt + {15'd0, ~r_status[ST_FCS_OK]};
  assign w_len_cnt_next = r_len_cnt + {15'd0, |r_status[ST_SHORT:ST_RUNT]};

  assign fcs_err_count_gray = r_fcs_gray;
  assign len_err_count_gray = r_len_gray;

  // Saturating byte count including the byte presented this cycle.
  always_comb begin
    if (w_start) begin
      w_count_next = LEN_W'(1);
    end else if (r_count == {LEN_W{1'b1}}) begin
      w_count_next = r_count;
    end else begin
      w_count_next = r_count + LEN_W'(1);
    end
  end

  // Frame verdict as it would stand if this byte is the last one.
  always_comb begin
    w_status_next            = 8'h00;
    w_status_next[ST_FCS_OK] = (w_crc_next == CRC_RESIDUE);
    w_status_next[ST_RUNT]   = (32'(w_count_next) < 32'(MIN_LEN));
    w_status_next[ST_GIANT]  = (32'(w_count_next) > 32'(MAX_LEN));
    w_status_next[ST_SHORT]  = (w_count_next <= LEN_W'(4));
  end

  // FIFO write port: zero-latency forward of the oldest delayed byte, or the status byte.
  always_comb begin
    fifo_wren   = 1'b0;
    fifo_EOD_in = 1'b0;
    fifo_din    = 8'h00;
    if (r_state == S_STATUS) begin
      fifo_wren   = 1'b1;
      fifo_EOD_in = 1'b1;
      fifo_din    = r_status;
    end else if ((r_state == S_STREAM) && in_valid) begin
      fifo_wren = 1'b1;
      fifo_din  = r_dly[3];
    end else begin
      fifo_wren = 1'b0;
    end
  end

  // Frame FSM, CRC, delay line and error counters.
  always_ff @(posedge REF_CLK or negedge arst_n) begin
    if (!arst_n) begin
      r_state    <= S_IDLE;
      r_crc      <= CRC_INIT;
      r_dly      <= 32'd0;
      r_fill     <= 3'd0;
      r_count    <= '0;
      r_status   <= 8'h00;
      r_fcs_cnt  <= 16'd0;
      r_len_cnt  <= 16'd0;
      r_fcs_gray <= 16'd0;
      r_len_gray <= 16'd0;
    end else begin
      if (r_state == S_STATUS) begin
        r_fcs_cnt  <= w_fcs_cnt_next;
        r_len_cnt  <= w_len_cnt_next;
        r_fcs_gray <= bin2gray(w_fcs_cnt_next);
        r_len_gray <= bin2gray(w_len_cnt_next);
      end
      if (in_valid) begin
        r_dly   <= {r_dly[2:0], in_data};
        r_crc   <= w_crc_next;
        r_count <= w_count_next;
        r_fill  <= w_fill_next;
        if (in_eod) begin
          r_status <= w_status_next;
          r_state  <= S_STATUS;
        end else if (w_fill_next == 3'd4) begin
          r_state <= S_STREAM;
        end else begin
          r_state <= S_FILL;
        end
      end else begin
        case (r_state)
          S_STATUS: begin
            r_state <= S_IDLE;
            r_crc   <= CRC_INIT;
            r_count <= '0;
            r_fill  <= 3'd0;
          end
          default: r_state <= r_state;
        endcase
      end
    end
  end

endmodule
